alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_op_decode.sv | 75 +++++++
 rtl/alu_op_sequencer.sv | 118 +++++++++++
 tb/tb_alu_op_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operation sequencer:
//   - alu_op_e    : 4-bit ALU operation codes (zero-extended to OP_W on output;
//                   ALU_NOP is the exception and widens to all-ones)
//   - seq_state_e : sequencer FSM state encoding
//   - ALUOP_*     : main-decoder class encodings carried on ALUOp
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_SLT  = 4'b0001,   // SLT and SLTI
        ALU_OR   = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_ADD  = 4'b0100,   // ADD, LW, SW, ADDI
        ALU_SLL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SUB  = 4'b1100,   // SUB and BEQ
        ALU_SUBI = 4'b1101,
        ALU_NOP  = 4'b1111    // widened to all-ones of the output width
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RFMT   = 2'b10;
    localparam logic [1:0] ALUOP_IFMT   = 2'b11;

endpackage

// File: rtl/alu_op_decode.sv
// -----------------------------------------------------------------------------
// alu_op_decode
// Purely combinational ALU control decode.
// Ports:
//   ALUOp    in  2     main-decoder class (mem / branch / R-format / I-format)
//   Funct    in  2     function field
//   opcode   in  4     instruction opcode
//   code     out OP_W  ALU operation code (all-ones for NOP)
//   is_shift out 1     decoded operation uses the iterative shifter
//   illegal  out 1     encoding is undefined (code is NOP)
// -----------------------------------------------------------------------------
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int OP_W     = 5,
    parameter int EN_SHIFT = 1
) (
    input  logic [1:0]      ALUOp,
    input  logic [1:0]      Funct,
    input  logic [3:0]      opcode,
    output logic [OP_W-1:0] code,
    output logic            is_shift,
    output logic            illegal
);

    alu_op_e op;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case statements can infer a latch.
        op       = ALU_NOP;
        is_shift = 1'b0;

        unique case (ALUOp)
            ALUOP_MEM:    op = ALU_ADD;
            ALUOP_BRANCH: op = ALU_SUB;
            ALUOP_RFMT: begin
                if (Funct == 2'b10) begin
                    op = ALU_XOR;                      // opcode is don't-care
                end else begin
                    unique case ({Funct, opcode})
                        6'b00_0000: op = ALU_AND;
                        6'b00_0001: op = ALU_ADD;
                        6'b01_0000: op = ALU_OR;
                        6'b01_0001: op = ALU_SUB;
                        default:    op = ALU_NOP;
                    endcase
                end
            end
            ALUOP_IFMT: begin
                unique case (opcode)
                    4'b1001: op = ALU_ADD;             // ADDI
                    4'b1010: op = ALU_SUBI;
                    4'b1011: op = ALU_SLT;             // SLTI
                    4'b0010: begin
                        // Shifts exist only when the shifter is built in.
                        if (EN_SHIFT != 0 && Funct == 2'b00) begin
                            op       = ALU_SLL;
                            is_shift = 1'b1;
                        end else if (EN_SHIFT != 0 && Funct == 2'b01) begin
                            op       = ALU_SRA;
                            is_shift = 1'b1;
                        end
                    end
                    default: op = ALU_NOP;
                endcase
            end
            default: op = ALU_NOP;
        endcase
    end

    assign illegal = (op == ALU_NOP);
    assign code    = illegal ? {OP_W{1'b1}} : OP_W'(op);

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Accepts one ALU control request at a time, decodes it and registers the
// operation code. Non-shift requests complete one cycle after accept at full
// throughput; shift requests hold the block busy for shamt cycles while
// stepping an external one-bit-per-cycle shifter, then complete.
// Ports:
//   clk         in  1        clock, rising edge
//   reset       in  1        synchronous, active-high reset
//   in_valid    in  1        request present
//   in_ready    out 1        block can accept (IDLE only)
//   ALUOp       in  2        main-decoder class
//   Funct       in  2        function field
//   opcode      in  4        instruction opcode
//   shamt       in  SHAMT_W  shift amount
//   out_valid   out 1        one-cycle completion pulse
//   Operacioni  out OP_W     registered ALU operation code
//   shift_step  out 1        one-bit shift enable to the iterative shifter
//   illegal     out 1        one-cycle pulse with out_valid on bad encoding
//   busy        out 1        not in_ready
// -----------------------------------------------------------------------------
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int OP_W     = 5,
    parameter int SHAMT_W  = 4,
    parameter int EN_SHIFT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         ALUOp,
    input  logic [1:0]         Funct,
    input  logic [3:0]         opcode,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    output logic [OP_W-1:0]    Operacioni,
    output logic               shift_step,
    output logic               illegal,
    output logic               busy
);

    seq_state_e         state, state_nxt;
    logic [SHAMT_W-1:0] count;
    logic               done_q;      // non-shift completion, one cycle after accept
    logic               illegal_q;

    logic [OP_W-1:0]    dec_code;
    logic               dec_shift;
    logic               dec_illegal;
    logic               accept;

    alu_op_decode #(
        .OP_W     (OP_W),
        .EN_SHIFT (EN_SHIFT)
    ) u_decode (
        .ALUOp    (ALUOp),
        .Funct    (Funct),
        .opcode   (opcode),
        .code     (dec_code),
        .is_shift (dec_shift),
        .illegal  (dec_illegal)
    );

    assign accept = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept && dec_shift) state_nxt = ST_RUN;
            ST_RUN:  if (count == '0)         state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath registers. Reset wins over a same-cycle accept because the
    // accept branch sits under the else.
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            Operacioni <= {OP_W{1'b1}};
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            done_q    <= accept && !dec_shift;
            illegal_q <= accept && dec_illegal;
            if (accept) begin
                Operacioni <= dec_code;
            end
            if (accept && dec_shift) begin
                count <= shamt;
            end else if (state == ST_RUN && count != '0) begin
                count <= count - SHAMT_W'(1);
            end
        end
    end

    // Outputs. A shift completes in the RUN cycle where the counter has
    // drained, so shamt == 0 finishes one cycle after accept with no step.
    always_comb begin
        in_ready   = (state == ST_IDLE);
        busy       = !in_ready;
        shift_step = (state == ST_RUN) && (count != '0);
        out_valid  = done_q || ((state == ST_RUN) && (count == '0));
        illegal    = illegal_q;
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
// Scoreboard bench: each driven request pushes its expected code, illegal flag,
// completion cycle and shift-step count; a negedge monitor pops on out_valid.
// A second instance with shifts disabled covers the EN_SHIFT=0 decode.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] ALUOp = 2'b00;
    logic [1:0] Funct = 2'b00;
    logic [3:0] opcode = 4'b0000;
    logic [3:0] shamt = 4'd0;

    logic       in_ready, out_valid, shift_step, illegal, busy;
    logic [4:0] Operacioni;
    logic       ns_in_ready, ns_out_valid, ns_shift_step, ns_illegal, ns_busy;
    logic [4:0] ns_Operacioni;

    always #5 clk = ~clk;

    alu_op_sequencer #(.OP_W(5), .SHAMT_W(4), .EN_SHIFT(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .Funct(Funct), .opcode(opcode), .shamt(shamt),
        .out_valid(out_valid), .Operacioni(Operacioni), .shift_step(shift_step),
        .illegal(illegal), .busy(busy)
    );

    alu_op_sequencer #(.OP_W(5), .SHAMT_W(4), .EN_SHIFT(0)) dut_ns (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ns_in_ready),
        .ALUOp(ALUOp), .Funct(Funct), .opcode(opcode), .shamt(shamt),
        .out_valid(ns_out_valid), .Operacioni(ns_Operacioni), .shift_step(ns_shift_step),
        .illegal(ns_illegal), .busy(ns_busy)
    );

    typedef struct {
        logic [4:0] code;
        logic       ill;
        int         due;
        int         steps;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   steps = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected decode, written from the operation table.
    function automatic void model(input logic [1:0] a, input logic [1:0] f, input logic [3:0] o,
                                  output logic [4:0] c, output logic il, output logic sh);
        c  = 5'b11111;
        sh = 1'b0;
        case (a)
            2'b00: c = 5'b00100;
            2'b01: c = 5'b01100;
            2'b10: begin
                if (f == 2'b10)                    c = 5'b00011;
                else if (f == 2'b00 && o == 4'd0)  c = 5'b00000;
                else if (f == 2'b00 && o == 4'd1)  c = 5'b00100;
                else if (f == 2'b01 && o == 4'd0)  c = 5'b00010;
                else if (f == 2'b01 && o == 4'd1)  c = 5'b01100;
            end
            default: begin
                if (o == 4'b1001)                      c = 5'b00100;
                else if (o == 4'b1010)                 c = 5'b01101;
                else if (o == 4'b1011)                 c = 5'b00001;
                else if (o == 4'b0010 && f == 2'b00) begin c = 5'b00110; sh = 1'b1; end
                else if (o == 4'b0010 && f == 2'b01) begin c = 5'b00111; sh = 1'b1; end
            end
        endcase
        il = (c == 5'b11111);
    endfunction

    // Waits (bounded) for in_ready at a negedge, drives the request there and
    // records what must come out. The following edge performs the accept.
    task automatic send(input logic [1:0] a, input logic [1:0] f, input logic [3:0] o,
                        input logic [3:0] s, input logic [4:0] c, input logic il, input logic sh);
        int waited = 0;
        exp_t e;
        @(negedge clk);
        while (!in_ready && waited < 64) begin
            in_valid = 1'b0;
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("ready_timeout", in_ready, 1);
        ALUOp = a; Funct = f; opcode = o; shamt = s; in_valid = 1'b1;
        e.code  = c;
        e.ill   = il;
        e.steps = sh ? int'(s) : 0;
        e.due   = cyc + 1 + e.steps;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            in_valid = 1'b0;
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every completion.
    always @(negedge clk) begin
        if (reset) begin
            steps = 0;
        end else begin
            if (shift_step) begin
                steps++;
                check("step_outside_run", in_ready, 0);
            end
            if (illegal) check("illegal_without_valid", out_valid, 1);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", out_valid, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("code", Operacioni, e.code);
                    check("illegal", illegal, e.ill);
                    check("latency_cycle", cyc, e.due);
                    check("shift_steps", steps, e.steps);
                end
                steps = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] a, f;
        logic [3:0] o, s;
        logic [4:0] c;
        logic       il, sh;
        logic [3:0] op_pick[8];

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_code", Operacioni, 5'b11111);
        check("rst_out_valid", out_valid, 0);
        check("rst_illegal", illegal, 0);
        check("rst_shift_step", shift_step, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        reset = 1'b0;

        // Non-shift requests back to back, one per cycle.
        send(2'b10, 2'b00, 4'b0000, 4'd0, 5'b00000, 0, 0);  // AND
        send(2'b00, 2'b11, 4'b0111, 4'd0, 5'b00100, 0, 0);  // LW/SW -> ADD
        send(2'b01, 2'b10, 4'b0101, 4'd0, 5'b01100, 0, 0);  // BEQ -> SUB
        send(2'b10, 2'b00, 4'b0001, 4'd0, 5'b00100, 0, 0);  // ADD
        send(2'b10, 2'b01, 4'b0000, 4'd0, 5'b00010, 0, 0);  // OR
        send(2'b10, 2'b01, 4'b0001, 4'd0, 5'b01100, 0, 0);  // SUB
        send(2'b10, 2'b10, 4'b0111, 4'd0, 5'b00011, 0, 0);  // XOR
        send(2'b11, 2'b11, 4'b1001, 4'd0, 5'b00100, 0, 0);  // ADDI
        send(2'b11, 2'b00, 4'b1010, 4'd0, 5'b01101, 0, 0);  // SUBI
        send(2'b11, 2'b10, 4'b1011, 4'd0, 5'b00001, 0, 0);  // SLTI
        send(2'b10, 2'b11, 4'b0000, 4'd0, 5'b11111, 1, 0);  // illegal Funct 11
        send(2'b10, 2'b00, 4'b0010, 4'd0, 5'b11111, 1, 0);  // illegal opcode
        send(2'b11, 2'b10, 4'b0010, 4'd0, 5'b11111, 1, 0);  // shift opcode, bad Funct
        drain();

        // R-format SUB: one-cycle completion, not illegal.
        send(2'b10, 2'b01, 4'b0001, 4'd0, 5'b01100, 0, 0);
        idle();
        check("sub_out_valid_t1", out_valid, 1);
        check("sub_busy_t1", busy, 0);

        // SLL shamt 3: steps at T+1..T+3, done at T+4, busy T+1..T+4.
        send(2'b11, 2'b00, 4'b0010, 4'd3, 5'b00110, 0, 1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("sll3_in_ready_t%0d", k), in_ready, 0);
            check($sformatf("sll3_step_t%0d", k), shift_step, (k <= 3) ? 1 : 0);
            check($sformatf("sll3_code_t%0d", k), Operacioni, 5'b00110);
        end
        @(negedge clk);
        check("sll3_ready_after", in_ready, 1);

        // SRA shamt 0: completes at T+1 with no step.
        send(2'b11, 2'b01, 4'b0010, 4'd0, 5'b00111, 0, 1);
        idle();
        check("sra0_out_valid_t1", out_valid, 1);
        check("sra0_step_t1", shift_step, 0);
        drain();

        // Undefined I-format opcode: single-cycle illegal pulse with NOP.
        send(2'b11, 2'b00, 4'b1111, 4'd0, 5'b11111, 1, 0);
        idle();
        check("ill_pulse", illegal, 1);
        check("ill_code", Operacioni, 5'b11111);
        @(negedge clk);
        check("ill_single_cycle", illegal, 0);
        check("ill_valid_single_cycle", out_valid, 0);

        // SLL on the shift-disabled instance decodes as illegal NOP.
        @(negedge clk);
        ALUOp = 2'b11; Funct = 2'b00; opcode = 4'b0010; shamt = 4'd2; in_valid = 1'b1;
        sb.push_back('{code: 5'b00110, ill: 1'b0, due: cyc + 3, steps: 2});
        @(negedge clk);
        in_valid = 1'b0;
        check("ns_sll_out_valid", ns_out_valid, 1);
        check("ns_sll_illegal", ns_illegal, 1);
        check("ns_sll_code", ns_Operacioni, 5'b11111);
        check("ns_sll_step", ns_shift_step, 0);
        drain();

        // Requests presented while busy are ignored.
        send(2'b11, 2'b00, 4'b0010, 4'd4, 5'b00110, 0, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ALUOp = 2'b10; Funct = 2'b10; opcode = 4'(k); shamt = 4'd9; in_valid = 1'b1;
        end
        idle();
        drain();
        check("busy_ignore_queue", sb.size(), 0);

        // Reset in the middle of a long shift aborts it silently.
        send(2'b11, 2'b00, 4'b0010, 4'd15, 5'b00110, 0, 1);
        idle();
        repeat (4) @(negedge clk);
        check("abort_still_stepping", shift_step, 1);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_code", Operacioni, 5'b11111);
        check("abort_in_ready", in_ready, 1);
        check("abort_step", shift_step, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready_after", in_ready, 1);
        check("abort_no_valid_after", out_valid, 0);

        // Reset beats a simultaneous accept.
        @(negedge clk);
        reset = 1'b1;
        ALUOp = 2'b10; Funct = 2'b00; opcode = 4'b0000; in_valid = 1'b1;
        @(negedge clk);
        check("rst_prio_code", Operacioni, 5'b11111);
        check("rst_prio_valid", out_valid, 0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_prio_code_after", Operacioni, 5'b11111);
        check("rst_prio_valid_after", out_valid, 0);

        // Random mix against the decode model.
        op_pick = '{4'b0000, 4'b0001, 4'b0010, 4'b1001, 4'b1010, 4'b1011, 4'b1111, 4'b0110};
        for (int i = 0; i < 40; i++) begin
            a = 2'($urandom_range(0, 3));
            f = 2'($urandom_range(0, 3));
            o = ($urandom_range(0, 3) == 0) ? 4'($urandom) : op_pick[$urandom_range(0, 7)];
            s = 4'($urandom_range(0, 5));
            model(a, f, o, c, il, sh);
            send(a, f, o, s, c, il, sh);
        end
        idle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
